// File: rtl/lemonpc_pkg.sv
// Shared LemonPC definitions: write-back FSM states and load funct3 encodings.
package lemonpc_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: shift the addressed lane down, then sign/zero-extend by funct3.
module load_extend
  import lemonpc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                      funct3,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
  input  logic [DATA_WIDTH-1:0]           word,
  output logic [DATA_WIDTH-1:0]           data
);

  logic [DATA_WIDTH-1:0] lane;

  always_comb begin
    lane = word >> {off, 3'b000};
    case (funct3)
      F3_LB:   data = DATA_WIDTH'($signed(lane[7:0]));
      F3_LH:   data = DATA_WIDTH'($signed(lane[15:0]));
      F3_LW:   data = DATA_WIDTH'($signed(lane[31:0]));
      F3_LBU:  data = DATA_WIDTH'(lane[7:0]);
      F3_LHU:  data = DATA_WIDTH'(lane[15:0]);
      F3_LWU:  data = DATA_WIDTH'(lane[31:0]);
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// LemonPC write-back stage: passes ALU results through, performs loads, drives the RF write port.
module writeback_unit
  import lemonpc_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_result,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic                  mem_resp_err,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic                  retire,
  output logic                  exc_misaligned,
  output logic                  exc_fault
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);

  wb_state_e             state, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_q_d, rf_rd_d;
  logic                  rd_wen_q, rd_wen_q_d;
  logic [2:0]            f3_q, f3_q_d;
  logic [OFF_W-1:0]      off_q, off_q_d;
  logic [DATA_WIDTH-1:0] data_d, addr_d, ext;
  logic                  req_v_d, wen_d, retire_d, mis_d, flt_d;
  logic                  mis_addr, bad_f3;

  assign in_ready = (state == IDLE);

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .funct3 (f3_q),
    .off    (off_q),
    .word   (mem_resp_data),
    .data   (ext)
  );

  always_comb begin
    case (in_funct3)
      F3_LH, F3_LHU: mis_addr = in_result[0];
      F3_LW, F3_LWU: mis_addr = (in_result[1:0] != 2'b00);
      F3_LD:         mis_addr = (in_result[2:0] != 3'b000);
      default:       mis_addr = 1'b0;
    endcase
    bad_f3 = (in_funct3 == 3'b111) ||
             ((DATA_WIDTH == 32) && (in_funct3 == F3_LD || in_funct3 == F3_LWU));
  end

  always_comb begin
    state_d    = state;
    rd_q_d     = rd_q;
    rd_wen_q_d = rd_wen_q;
    f3_q_d     = f3_q;
    off_q_d    = off_q;
    rf_rd_d    = rf_rd;
    data_d     = rf_dataD;
    addr_d     = mem_req_addr;
    req_v_d    = mem_req_valid;
    wen_d      = 1'b0;
    retire_d   = 1'b0;
    mis_d      = 1'b0;
    flt_d      = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        rd_q_d     = in_rd;
        rd_wen_q_d = in_rd_wen;
        f3_q_d     = in_funct3;
        off_q_d    = in_result[OFF_W-1:0];
        if (!in_is_load) begin
          state_d  = WB;
          retire_d = 1'b1;
          wen_d    = in_rd_wen && (in_rd != '0);
          rf_rd_d  = in_rd;
          data_d   = in_result;
        end else if (mis_addr || bad_f3) begin
          // Faulting load never reaches memory; it retires with the flag only.
          state_d  = WB;
          retire_d = 1'b1;
          mis_d    = 1'b1;
          rf_rd_d  = in_rd;
          data_d   = in_result;
        end else begin
          state_d             = REQ;
          req_v_d             = 1'b1;
          addr_d              = in_result;
          addr_d[OFF_W-1:0]   = '0;
        end
      end
      REQ: if (mem_req_ready) begin
        req_v_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: if (mem_resp_valid) begin
        state_d  = WB;
        retire_d = 1'b1;
        flt_d    = mem_resp_err;
        wen_d    = rd_wen_q && (rd_q != '0) && !mem_resp_err;
        rf_rd_d  = rd_q;
        data_d   = ext;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_q           <= '0;
      rd_wen_q       <= 1'b0;
      f3_q           <= '0;
      off_q          <= '0;
      rf_rd          <= '0;
      rf_dataD       <= '0;
      mem_req_addr   <= '0;
      mem_req_valid  <= 1'b0;
      rf_wen         <= 1'b0;
      retire         <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_fault      <= 1'b0;
    end else begin
      state          <= state_d;
      rd_q           <= rd_q_d;
      rd_wen_q       <= rd_wen_q_d;
      f3_q           <= f3_q_d;
      off_q          <= off_q_d;
      rf_rd          <= rf_rd_d;
      rf_dataD       <= data_d;
      mem_req_addr   <= addr_d;
      mem_req_valid  <= req_v_d;
      rf_wen         <= wen_d;
      retire         <= retire_d;
      exc_misaligned <= mis_d;
      exc_fault      <= flt_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected write-backs queued at issue, checked on retire.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_rd_wen, in_is_load;
  logic [4:0]  in_rd, rf_rd;
  logic [2:0]  in_funct3;
  logic [31:0] in_result, mem_req_addr, mem_resp_data, rf_dataD;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_err;
  logic        rf_wen, retire, exc_misaligned, exc_fault;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chkd;
    logic        mis;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_result(in_result),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD),
    .retire(retire), .exc_misaligned(exc_misaligned), .exc_fault(exc_fault)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every retire consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && retire) begin
      if (sb.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rf_wen", rf_wen, e.wen);
        chk("rf_rd", rf_rd, e.rd);
        chk("exc_misaligned", exc_misaligned, e.mis);
        chk("exc_fault", exc_fault, e.flt);
        if (e.chkd) chk("rf_dataD", rf_dataD, e.data);
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in 5000 cycles");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_req_valid"}, mem_req_valid, 0);
    chk({tag, "_rf_wen"}, rf_wen, 0);
    chk({tag, "_retire"}, retire, 0);
    chk({tag, "_exc"}, {exc_misaligned, exc_fault}, 0);
    chk({tag, "_rf_rd"}, rf_rd, 0);
    chk({tag, "_rf_dataD"}, rf_dataD, 0);
    chk({tag, "_req_addr"}, mem_req_addr, 0);
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [2:0] f3, input logic [31:0] res);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_rd = rd; in_rd_wen = wen; in_is_load = ld; in_funct3 = f3; in_result = res;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    sb.push_back('{wen: (rd != 0), rd: rd, data: res, chkd: 1'b1, mis: 1'b0, flt: 1'b0});
    issue(rd, 1'b1, 1'b0, 3'b000, res);
  endtask

  task automatic bad_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] addr);
    sb.push_back('{wen: 1'b0, rd: rd, data: 32'h0, chkd: 1'b0, mis: 1'b1, flt: 1'b0});
    issue(rd, 1'b1, 1'b1, f3, addr);
    @(negedge clk);
    chk({tag, "_no_req"}, mem_req_valid, 0);
  endtask

  // Drives one load through the memory handshake; optional spurious responses during REQ.
  task automatic load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [31:0] addr, input int reqdly, input int rspdly,
                      input logic [31:0] word, input logic err, input logic spur,
                      input logic [31:0] exp_data);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    sb.push_back('{wen: (!err && rd != 0), rd: rd, data: exp_data, chkd: !err, mis: 1'b0, flt: err});
    issue(rd, 1'b1, 1'b1, f3, addr);
    for (int i = 0; i < reqdly; i++) begin
      mem_resp_valid = spur; mem_resp_data = 32'h5A5A_5A5A; mem_resp_err = spur;
      @(negedge clk);
      chk({tag, "_req_valid_hold"}, mem_req_valid, 1);
      chk({tag, "_req_addr_hold"}, mem_req_addr, exp_addr);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_req_valid"}, mem_req_valid, 1);
    chk({tag, "_req_addr"}, mem_req_addr, exp_addr);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    repeat (rspdly) begin @(posedge clk); #1; end
    mem_resp_valid = 1'b1; mem_resp_data = word; mem_resp_err = err;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_rd = 0; in_rd_wen = 0; in_is_load = 0; in_funct3 = 0; in_result = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through and in_ready low for exactly one cycle
    alu(5'd5, 32'h1234_5678);
    @(negedge clk);
    chk("alu_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("alu_in_ready_back", in_ready, 1);
    alu(5'd0, 32'h1234_5678);
    alu(5'd31, 32'hFFFF_FFFF);

    load("lb", 5'd7, 3'b000, 32'h0000_0103, 2, 0, 32'h80AA_BBCC, 1'b0, 1'b0, 32'hFFFF_FF80);
    load("lbu", 5'd7, 3'b100, 32'h0000_0103, 2, 1, 32'h80AA_BBCC, 1'b0, 1'b0, 32'h0000_0080);
    load("lh", 5'd8, 3'b001, 32'h0000_0042, 0, 0, 32'h8001_1234, 1'b0, 1'b0, 32'hFFFF_8001);
    load("lhu", 5'd8, 3'b101, 32'h0000_0042, 0, 2, 32'h8001_1234, 1'b0, 1'b0, 32'h0000_8001);
    load("lb_pos", 5'd3, 3'b000, 32'h0000_0011, 0, 0, 32'h1122_7F44, 1'b0, 1'b0, 32'h0000_007F);

    bad_load("mis_lh", 5'd9, 3'b001, 32'h0000_0101);
    bad_load("mis_lw", 5'd9, 3'b010, 32'h0000_0202);
    bad_load("ill_ld", 5'd9, 3'b011, 32'h0000_0200);
    bad_load("ill_lwu", 5'd9, 3'b110, 32'h0000_0200);
    bad_load("ill_111", 5'd9, 3'b111, 32'h0000_0200);

    load("lw_fault", 5'd10, 3'b010, 32'h0000_0200, 0, 1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);

    // Spurious response while IDLE, then during REQ; only the real one counts.
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD_0BAD; mem_resp_err = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    @(negedge clk);
    chk("idle_spur_no_retire", retire, 0);
    load("lw_spur", 5'd11, 3'b010, 32'h0000_0300, 2, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Reset while waiting for the response; the late response must be dropped.
    issue(5'd12, 1'b1, 1'b1, 3'b010, 32'h0000_0400);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("late_resp");
    @(negedge clk);
    chk("late_resp_no_retire", retire, 0);

    alu(5'd13, 32'hA5A5_0001);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the LemonPC core, directly upstream of the register file. It accepts one retiring instruction at a time from execute. ALU results pass straight through. Loads issue a single memory read, then byte-select and sign- or zero-extend the response. The stage then drives the register file's write port (`rd`, `wen`, `dataD`) for exactly one cycle per instruction.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, register index width; matches the register file.
- `DATA_WIDTH`, 32, XLEN. Legal values are 32 or 64 only.

Ports:
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `in_valid`  in  1  Execute presents a retiring instruction.
- `in_ready`  out  1  Stage can accept an instruction.
- `in_rd`  in  ADDR_WIDTH  Destination register.
- `in_rd_wen`  in  1  Instruction writes `rd`.
- `in_is_load`  in  1  Instruction is a load.
- `in_funct3`  in  3  Load size and sign.
- `in_result`  in  DATA_WIDTH  ALU result; this is the load address when `in_is_load`.
- `mem_req_valid`  out  1  Read request.
- `mem_req_ready`  in  1  Memory accepts the request.
- `mem_req_addr`  out  DATA_WIDTH  Word-aligned address: low log2(DATA_WIDTH/8) bits are 0.
- `mem_resp_valid`  in  1  Read data valid.
- `mem_resp_data`  in  DATA_WIDTH  Full aligned word.
- `mem_resp_err`  in  1  Access fault; qualified by `mem_resp_valid`.
- `rf_wen`  out  1  Connects to register file `wen`.
- `rf_rd`  out  ADDR_WIDTH  Connects to register file `rd`.
- `rf_dataD`  out  DATA_WIDTH  Connects to register file `dataD`.
- `retire`  out  1  One-cycle pulse per completed instruction.
- `exc_misaligned`  out  1  Misaligned load; valid with `retire`.
- `exc_fault`  out  1  Load access fault; valid with `retire`.

## Operation
- States:
  - IDLE, REQ, WAIT, WB.
  - `in_ready` = (state == IDLE).
- IDLE:
  - On `in_valid && in_ready`, capture `rd`, `rd_wen`, `funct3`, `result` and `is_load`.
  - Non-load goes to WB.
  - Load that is aligned and has a legal `funct3` goes to REQ.
  - Misaligned load goes to WB with the misaligned flag set. Misaligned means: LH/LHU with addr[0]=1; LW/LWU with addr[1:0]≠0; LD with addr[2:0]≠0.
  - An illegal `funct3` also goes to WB with the misaligned flag set. Illegal means 011 or 110 when DATA_WIDTH=32, or 111 at any width.
- REQ:
  - `mem_req_valid`=1 and `mem_req_addr` stay stable until `mem_req_ready`.
  - Handshake goes to WAIT.
- WAIT:
  - On `mem_resp_valid`, latch the extended data and `mem_resp_err`, then go to WB.
  - `mem_resp_valid` outside WAIT is ignored.
- WB:
  - One cycle, then go to IDLE.
  - `retire`=1.
  - `rf_wen` = `rd_wen` && rd≠0 && no exception.
  - `rf_dataD` = captured ALU result (non-load) or extended load data.
  - On an exception, `rf_wen`=0. `exc_misaligned` or `exc_fault` is set; the two are mutually exclusive.
- Load extract:
  - Lane = `mem_resp_data` >> (8 × addr offset).
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes through.
- Reset mid-operation:
  - All state goes to IDLE and the captured instruction is dropped; no write is issued.
  - A late memory response after reset is ignored.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=1.
  - `mem_req_valid`, `rf_wen`, `retire`, `exc_*`=0.
  - `rf_rd`=0, `rf_dataD`=0, `mem_req_addr`=0.
- All outputs except `in_ready` are registered.
- Non-load, accepted at edge N:
  - `rf_wen`/`retire` are high during cycle N+1.
  - The register file writes at edge N+2.
  - `in_ready` returns to 1 in cycle N+2.
- Load latency:
  - 1 cycle accept, plus REQ cycles until ready, plus WAIT cycles until response, plus 1 WB cycle.
  - Minimum 3 cycles from accept to `rf_wen`.
- `mem_req_ready` may be high in the first REQ cycle (zero wait).
- A response in the cycle of the request handshake is not permitted; memory responds ≥1 cycle later.
- Throughput: at most one instruction per 2 cycles. Execute holds its inputs while `in_ready`=0.

## Structure
- `lemonpc_pkg` holds:
  - The state enum (IDLE/REQ/WAIT/WB).
  - `funct3` constants: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
- Sub-module `load_extend`: combinational. Inputs are `funct3`, byte offset and the response word; output is the extended data. It is shared with a future store-data/forwarding path.
- The FSM and capture registers stay in `writeback_unit`.

## Test plan
- ADD result 0x1234_5678 to rd=5, `in_rd_wen`=1 → `rf_wen`=1, `rf_rd`=5, `rf_dataD`=0x12345678, `retire` for one cycle; `in_ready` low for exactly 1 cycle.
- Same instruction with rd=0 → `retire`=1, `rf_wen`=0.
- LB at addr 0x103, response 0x80AA_BBCC, `mem_req_ready` delayed 2 cycles → `mem_req_addr`=0x100 held stable; `rf_dataD`=0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- LH at 0x101 → no `mem_req_valid`; `retire`=1, `exc_misaligned`=1, `rf_wen`=0. LW at 0x200 with `mem_resp_err`=1 → `exc_fault`=1, `rf_wen`=0.
- Spurious `mem_resp_valid` during IDLE and REQ → ignored; the later real response 0xDEAD_BEEF for LW is written.
- Assert `rst_n` low while in WAIT, then respond → no `rf_wen`, state IDLE, `in_ready`=1, all outputs at reset values.
